// File: rtl/pe_out_drain.sv
// Column drain: requantizes accumulator results to the signed operand format,
// buffers them in a small FIFO and streams them out with tile framing and a sticky saturation flag.
module pe_out_drain #(
    parameter int INT_BW = 5,
    parameter int FRA_BW = 6,
    parameter int MUL_BW = 16,
    parameter int ACC_BW = 32,
    parameter int DEPTH  = 8,
    parameter int LEN_BW = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_vld,
    output logic                       in_rdy,
    input  logic signed [ACC_BW-1:0]   in_data,
    input  logic        [LEN_BW-1:0]   cfg_len,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic signed [MUL_BW-1:0]   out_data,
    output logic                       out_last,
    output logic                       sat_o,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_BW = $clog2(DEPTH);
    localparam int LVL_BW = $clog2(DEPTH + 1);

    localparam logic signed [ACC_BW-1:0] Q_MAX = ACC_BW'((2 ** (INT_BW + FRA_BW)) - 1);
    localparam logic signed [ACC_BW-1:0] Q_MIN = ~Q_MAX;

    logic [MUL_BW-1:0] mem [DEPTH];
    logic [PTR_BW-1:0] wr_ptr;
    logic [PTR_BW-1:0] rd_ptr;
    logic [LEN_BW-1:0] pop_cnt;
    logic [LEN_BW-1:0] last_idx;

    logic signed [ACC_BW-1:0] shifted;
    logic        [MUL_BW-1:0] q_word;
    logic                     word_sat;
    logic                     push;
    logic                     pop;

    // Requantize before the FIFO write so the stored word is already in operand format.
    assign shifted = in_data >>> FRA_BW;

    always_comb begin
        q_word   = MUL_BW'(shifted);
        word_sat = 1'b0;
        if (shifted > Q_MAX) begin
            q_word   = MUL_BW'(Q_MAX);
            word_sat = 1'b1;
        end else if (shifted < Q_MIN) begin
            q_word   = MUL_BW'(Q_MIN);
            word_sat = 1'b1;
        end
    end

    assign in_rdy   = (level != LVL_BW'(DEPTH));
    assign out_vld  = (level != '0);
    assign out_data = mem[rd_ptr];
    assign push     = in_vld && in_rdy;
    assign pop      = out_vld && out_rdy;

    // A zero-length tile behaves as a one-word tile.
    assign last_idx = (cfg_len == '0) ? '0 : cfg_len - 1'b1;
    assign out_last = out_vld && (pop_cnt == last_idx);

    // NOTE: the storage array has no reset; words are only observable once level says they were written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= q_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            pop_cnt <= '0;
            sat_o   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                pop_cnt <= out_last ? '0 : pop_cnt + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            // A saturating push landing on the closing pop marks the next tile.
            if (push && word_sat) begin
                sat_o <= 1'b1;
            end else if (pop && out_last) begin
                sat_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pe_out_drain.sv
// Self-checking bench for pe_out_drain: a queue-based reference model compared every cycle,
// plus directed vectors with hand-computed expectations.
module tb_pe_out_drain;

    localparam int INT_BW = 5;
    localparam int FRA_BW = 6;
    localparam int MUL_BW = 16;
    localparam int ACC_BW = 32;
    localparam int DEPTH  = 8;
    localparam int LEN_BW = 8;
    localparam int LVL_BW = $clog2(DEPTH + 1);

    logic                     clk     = 1'b0;
    logic                     rst     = 1'b1;
    logic                     in_vld  = 1'b0;
    logic                     in_rdy;
    logic signed [ACC_BW-1:0] in_data = '0;
    logic        [LEN_BW-1:0] cfg_len = 8'd1;
    logic                     out_vld;
    logic                     out_rdy = 1'b1;
    logic signed [MUL_BW-1:0] out_data;
    logic                     out_last;
    logic                     sat_o;
    logic [LVL_BW-1:0]        level;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model state: buffered words, words popped so far in the tile, sticky flag.
    longint m_q[$];
    int     m_pos = 0;
    bit     m_sat = 1'b0;

    pe_out_drain #(
        .INT_BW(INT_BW), .FRA_BW(FRA_BW), .MUL_BW(MUL_BW),
        .ACC_BW(ACC_BW), .DEPTH(DEPTH), .LEN_BW(LEN_BW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
        .cfg_len(cfg_len),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
        .out_last(out_last), .sat_o(sat_o), .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Floor division by 2^FRA_BW, then clamp to the operand range.
    function automatic void quant(input longint v, output longint q, output bit s);
        longint scale = longint'(1) << FRA_BW;
        longint fl    = v / scale;
        longint mx    = (longint'(1) << (INT_BW + FRA_BW)) - 1;
        longint mn    = -(longint'(1) << (INT_BW + FRA_BW));
        if ((v % scale != 0) && (v < 0)) fl = fl - 1;
        s = 1'b0;
        q = fl;
        if (fl > mx) begin q = mx; s = 1'b1; end
        if (fl < mn) begin q = mn; s = 1'b1; end
    endfunction

    function automatic int tile_len();
        return (cfg_len == 0) ? 1 : int'(cfg_len);
    endfunction

    always @(posedge clk) begin
        longint q;
        bit     s;
        bit     do_push;
        bit     do_pop;
        bit     is_last;
        if (rst) begin
            m_q.delete();
            m_pos = 0;
            m_sat = 1'b0;
        end else begin
            do_push = in_vld && (m_q.size() < DEPTH);
            do_pop  = out_rdy && (m_q.size() > 0);
            is_last = (m_q.size() > 0) && (m_pos == tile_len() - 1);
            quant(longint'(in_data), q, s);
            if (do_pop) begin
                void'(m_q.pop_front());
                m_pos = is_last ? 0 : m_pos + 1;
            end
            if (do_push) m_q.push_back(q);
            if (do_push && s)            m_sat = 1'b1;
            else if (do_pop && is_last)  m_sat = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_level", level, m_q.size());
            check("m_out_vld", out_vld, m_q.size() != 0);
            check("m_in_rdy", in_rdy, m_q.size() != DEPTH);
            check("m_sat", sat_o, m_sat);
            check("m_last", out_last, (m_q.size() != 0) && (m_pos == tile_len() - 1));
            if (m_q.size() != 0) check("m_data", out_data, m_q[0]);
        end
    end

    task automatic single(input int din, input int exp, input bit exp_sat);
        in_data = din;
        in_vld  = 1'b1;
        step();
        in_vld = 1'b0;
        check("single_vld", out_vld, 1);
        check("single_data", out_data, exp);
        check("single_sat", sat_o, exp_sat);
        step();
        check("single_level", level, 0);
    endtask

    int fw[9]      = '{64, 1048576, 192, 256, 320, 384, 448, 512, 576};
    int fw_d[9]    = '{1, 2047, 3, 4, 5, 6, 7, 8, 9};
    bit fw_last[9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
    bit fw_sat[9]  = '{0, 1, 1, 0, 0, 0, 0, 0, 0};

    initial begin
        step();
        step();
        check("rst_level", level, 0);
        check("rst_out_vld", out_vld, 0);
        check("rst_in_rdy", in_rdy, 1);
        check("rst_sat", sat_o, 0);
        check("rst_last", out_last, 0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Basic path, rounding and saturation, one-word tiles.
        out_rdy = 1'b1;
        single(4160, 65, 0);
        single(-200, -4, 0);
        single(1048576, 2047, 1);
        single(-1048576, -2048, 1);
        single(131071, 2047, 0);

        // Backpressure: fill, reject a ninth word, then drain in order.
        out_rdy = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            in_data = k * 64;
            in_vld  = 1'b1;
            step();
        end
        check("full_in_rdy", in_rdy, 0);
        check("full_level", level, 8);
        in_data = 9 * 64;
        step();
        in_vld = 1'b0;
        check("full_reject", level, 8);
        check("full_head", out_data, 1);
        out_rdy = 1'b1;
        step();
        check("drain_in_rdy", in_rdy, 1);
        check("drain_data", out_data, 2);
        for (int k = 3; k <= 8; k++) begin
            step();
            check("drain_data", out_data, k);
        end
        step();
        check("drain_level", level, 0);

        // Concurrent push and pop at level 4 across pointer wrap.
        out_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_data = (100 + k) * 64;
            in_vld  = 1'b1;
            step();
        end
        out_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = (104 + i) * 64;
            step();
            check("conc_level", level, 4);
        end
        check("conc_head", out_data, 120);
        in_vld = 1'b0;
        repeat (4) step();
        check("conc_empty", level, 0);

        // Framing with cfg_len = 3 and a saturated second word.
        cfg_len = 8'd3;
        for (int k = 0; k < 9; k++) begin
            in_data = fw[k];
            in_vld  = 1'b1;
            step();
            check("frame_data", out_data, fw_d[k]);
            check("frame_last", out_last, fw_last[k]);
            check("frame_sat", sat_o, fw_sat[k]);
        end
        in_vld = 1'b0;
        step();

        // Zero length: every word closes its own tile.
        cfg_len = 8'd0;
        for (int k = 1; k <= 3; k++) begin
            in_data = k * 64;
            in_vld  = 1'b1;
            step();
            check("len0_last", out_last, 1);
        end
        in_vld = 1'b0;
        step();

        // Mid-tile reset with a partly filled FIFO.
        cfg_len = 8'd4;
        in_data = 64;  in_vld = 1'b1; step();
        in_data = 128; step();
        in_vld = 1'b0; step();
        out_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_data = (k == 2) ? 1048576 : (k + 3) * 64;
            in_vld  = 1'b1;
            step();
        end
        check("pre_rst_level", level, 5);
        check("pre_rst_sat", sat_o, 1);
        rst     = 1'b1;
        in_data = 640;
        step();
        rst    = 1'b0;
        in_vld = 1'b0;
        check("mid_rst_level", level, 0);
        check("mid_rst_vld", out_vld, 0);
        check("mid_rst_sat", sat_o, 0);
        check("mid_rst_in_rdy", in_rdy, 1);
        out_rdy = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_data = k * 64;
            in_vld  = 1'b1;
            step();
            check("post_rst_data", out_data, k);
            check("post_rst_last", out_last, k == 4);
        end
        in_vld = 1'b0;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_out_drain.md
# pe_out_drain

Output drain stage that sits directly downstream of the last PE of each systolic column. It accepts the column's ACC_BW-bit accumulator results, requantizes them to the signed MUL_BW fixed-point operand format used by the PE multipliers, and buffers them in a small FIFO. It presents them on a valid/ready stream with per-tile framing (`out_last`) and a sticky saturation flag. One instance exists per column.

## Interface
Parameters:
- INT_BW, 5, integer bits of the operand format
- FRA_BW, 6, fraction bits of the operand format; accumulator carries 2*FRA_BW fraction bits
- MUL_BW, 16, output word width
- ACC_BW, 32, input accumulator width
- DEPTH, 8, FIFO entries (power of two, >= 2)
- LEN_BW, 8, width of tile-length configuration

Ports:
- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- in_vld  in  1  accumulator word valid
- in_rdy  out  1  drain can accept a word
- in_data  in  ACC_BW  signed accumulator word from column tail PE
- cfg_len  in  LEN_BW  results per tile; static while level != 0
- out_vld  out  1  out_data valid
- out_rdy  in  1  consumer accepts word
- out_data  out  MUL_BW  signed requantized word
- out_last  out  1  current out_data is last word of tile
- sat_o  out  1  sticky: a word of the current tile saturated
- level  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
- Push when in_vld && in_rdy. Pop when out_vld && out_rdy.
- Requantize at push (combinational, before FIFO write): s = in_data >>> FRA_BW (arithmetic, floor). Let MAX = 2^(INT_BW+FRA_BW)-1 and MIN = -2^(INT_BW+FRA_BW) (defaults: 2047 and -2048).
  - If s > MAX, store MAX and flag saturation.
  - If s < MIN, store MIN and flag saturation.
  - Otherwise store s sign-extended to MUL_BW.
- FIFO: DEPTH-entry register array; write pointer, read pointer and count, with pointers wrapping modulo DEPTH.
  - in_rdy = (level != DEPTH). It does not depend on out_rdy, so a push while full is never accepted.
  - out_vld = (level != 0). out_data = mem[rd_ptr].
- Simultaneous push and pop: level is unchanged and both pointers advance. This is legal at any level 1..DEPTH-1.
- Tile counter pop_cnt (LEN_BW bits):
  - Increments on each pop.
  - Returns to 0 on the pop where out_last = 1.
  - out_last = out_vld && (pop_cnt == cfg_len-1).
  - cfg_len = 0 is treated as 1, so every word is last.
- sat_o:
  - Set on any push whose word saturated.
  - Cleared on the pop with out_last = 1.
  - If a saturating push coincides with that pop, set wins; the flag then belongs to the next tile.
- No gemm/unary mode dependence. Every accepted word is requantized identically.

## Timing
- Reset (rst high at a clk edge): level = 0, pointers = 0, pop_cnt = 0, sat_o = 0, out_vld = 0, out_last = 0, in_rdy = 1. out_data is don't-care while out_vld = 0, but the FIFO memory is not reset.
- Reset mid-operation discards all buffered words and the partial tile count. In-flight input is ignored on the reset cycle.
- Latency: a word pushed at edge N is visible on out_data with out_vld = 1 after edge N (cycle N+1) when the FIFO was empty. There is no combinational in-to-out path.
- in_rdy, out_vld, out_last, sat_o and level are all functions of registered state only (plus cfg_len for out_last).
- Throughput: 1 word/cycle sustained when out_rdy is held high.
- Full: after DEPTH pushes with no pop, in_rdy = 0 in the next cycle. It returns to 1 the cycle after the first pop.
- Empty: out_vld = 0. A pop is never accepted, and pop_cnt holds.

## Test plan
- Basic path: push in_data = 4160 (0x1040), out_rdy = 1 → out_data = 65 one cycle later, sat_o = 0, level returns to 0.
- Rounding and saturation:
  - Push -200 → -4.
  - Push 1048576 → 2047 with sat_o = 1.
  - Push -1048576 → -2048.
  - Push 131071 → 2047 (s = 2047 exactly, sat_o stays clear if it is alone in a fresh tile).
- Backpressure: out_rdy = 0, push 8 words 1..8 (× 64) → in_rdy = 0 after the 8th, and a 9th in_vld is ignored. Release out_rdy → 1..8 in order, with in_rdy = 1 the cycle after the first pop.
- Concurrent push/pop at level 4 for 20 cycles → level stays 4, data order preserved across pointer wrap.
- Framing: cfg_len = 3, stream 7 words → out_last on words 3 and 6. A saturation in word 2 keeps sat_o = 1 until word 3 pops, then clears. cfg_len = 0 → out_last on every word.
- Reset with level = 5 and pop_cnt = 2 → next cycle level = 0, out_vld = 0, sat_o = 0. The following tile's out_last lands on word cfg_len.
